fetch_unit: RTL and testbench

Instruction fetch stage feeding the combinational word-addressed instruction memory. It owns the program counter and drives the memory address. It captures the returned instruction word with its PC into a small FIFO and presents it to decode over a valid/ready handshake. It accepts branch/jump redirects, which flush buffered instructions, and flags fetches beyond the memory range.

---
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC, fetch FIFO, redirect flush and range fault.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          DEPTH     = 2,
   parameter int          MEM_WORDS = 32
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        fault,
   output logic        misaligned
);
   localparam int          AW     = $clog2(DEPTH);
   localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
   localparam logic [31:0] PC_END = 32'(MEM_WORDS * 4);

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [31:0]   hold_pc_q, hold_instr_q;
   logic          mis_q;
   logic          push, pop;

   assign imem_addr  = pc_q;
   assign fault      = pc_q >= PC_END;
   assign out_valid  = cnt_q != '0;
   assign pop        = out_valid & out_ready;
   assign push       = fetch_en & ~redirect_valid & ~fault & ((cnt_q < FULL) | pop);
   assign misaligned = mis_q;
   // Empty FIFO shows whatever the head last presented.
   assign out_pc     = out_valid ? pc_mem[rd_q]    : hold_pc_q;
   assign out_instr  = out_valid ? instr_mem[rd_q] : hold_instr_q;

   always_comb begin
      pc_d  = redirect_valid ? {redirect_pc[31:2], 2'b00} : push ? pc_q + 32'd4 : pc_q;
      wr_d  = redirect_valid ? '0 : push ? wr_q + AW'(1) : wr_q;
      rd_d  = redirect_valid ? '0 : pop ? rd_q + AW'(1) : rd_q;
      cnt_d = redirect_valid ? '0 :
              (push & ~pop) ? cnt_q + (AW+1)'(1) :
              (pop & ~push) ? cnt_q - (AW+1)'(1) : cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         wr_q         <= '0;
         rd_q         <= '0;
         cnt_q        <= '0;
         hold_pc_q    <= '0;
         hold_instr_q <= '0;
         mis_q        <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         mis_q <= redirect_valid & |redirect_pc[1:0];
         if (out_valid) begin
            hold_pc_q    <= pc_mem[rd_q];
            hold_instr_q <= instr_mem[rd_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_q]    <= pc_q;
         instr_mem[wr_q] <= imem_data;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit; expected deliveries queued as stimulus is driven.
module tb_fetch_unit;
   logic        clk, rst;
   logic [31:0] imem_addr, imem_data;
   logic        fetch_en, redirect_valid, out_valid, out_ready, fault, misaligned;
   logic [31:0] redirect_pc, out_pc, out_instr;
   logic [31:0] mem [32];
   logic [63:0] exp_q [$];
   int          n_chk, n_fail;

   fetch_unit dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
      .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .fault(fault), .misaligned(misaligned)
   );

   assign imem_data = mem[imem_addr[6:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic exp_push(input logic [31:0] pc);
      exp_q.push_back({pc, mem[pc[6:2]]});
   endtask

   task automatic drain();
      for (int i = 0; i < 12 && exp_q.size() != 0; i++) tick();
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   // Every accepted handshake is compared against the next expected delivery.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("spurious", 64'(exp_q.size()), 64'd1);
         else chk("deliver", {out_pc, out_instr}, exp_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = {16'hC0DE, 16'(i * 4)};
      mem[0] = 32'h0000_0013;
      mem[1] = 32'h0010_0093;
      rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      tick(); tick();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_pc", 64'(out_pc), 64'd0);
      chk("rst_instr", 64'(out_instr), 64'd0);
      chk("rst_mis", 64'(misaligned), 64'd0);
      chk("rst_addr", 64'(imem_addr), 64'd0);
      chk("rst_fault", 64'(fault), 64'd0);
      // Straight-line fetch after reset release
      exp_push(0); exp_push(4); exp_push(8);
      rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
      #1;
      chk("s1_addr0", 64'(imem_addr), 64'd0);
      chk("s1_valid0", 64'(out_valid), 64'd0);
      tick();
      chk("s1_addr4", 64'(imem_addr), 64'd4);
      chk("s1_valid1", 64'(out_valid), 64'd1);
      tick();
      chk("s1_addr8", 64'(imem_addr), 64'd8);
      tick();
      fetch_en = 1'b0;
      drain();
      chk("s1_freeze", 64'(imem_addr), 64'd12);
      // Backpressure fills the FIFO, then releases in order
      rst = 1'b1; tick();
      rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b0;
      exp_push(0); exp_push(4); exp_push(8); exp_push(12);
      repeat (5) tick();
      chk("bp_addr", 64'(imem_addr), 64'd8);
      chk("bp_pc", 64'(out_pc), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      tick(); tick();
      fetch_en = 1'b0;
      drain();
      // Redirect with a pop in the same cycle
      out_ready = 1'b0; fetch_en = 1'b1;
      tick(); tick();
      chk("rd_head", 64'(out_pc), 64'h10);
      exp_push(32'h10);
      redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
      tick();
      redirect_valid = 1'b0;
      chk("rd_addr", 64'(imem_addr), 64'h40);
      chk("rd_flush", 64'(out_valid), 64'd0);
      chk("rd_mis", 64'(misaligned), 64'd0);
      exp_push(32'h40); exp_push(32'h44);
      tick(); tick();
      fetch_en = 1'b0;
      drain();
      // Misaligned redirect, honoured while fetch_en=0
      redirect_valid = 1'b1; redirect_pc = 32'h23;
      tick();
      redirect_valid = 1'b0;
      chk("mis_pulse", 64'(misaligned), 64'd1);
      chk("mis_addr", 64'(imem_addr), 64'h20);
      exp_push(32'h20); fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
      chk("mis_clear", 64'(misaligned), 64'd0);
      drain();
      // Last memory word, then fault until redirected back in range
      redirect_valid = 1'b1; redirect_pc = 32'h7C; fetch_en = 1'b1;
      tick();
      redirect_valid = 1'b0;
      chk("end_fault0", 64'(fault), 64'd0);
      chk("end_addr", 64'(imem_addr), 64'h7C);
      exp_push(32'h7C);
      tick();
      chk("end_fault1", 64'(fault), 64'd1);
      chk("end_addr80", 64'(imem_addr), 64'h80);
      repeat (3) tick();
      chk("end_novalid", 64'(out_valid), 64'd0);
      chk("end_hold", 64'(imem_addr), 64'h80);
      drain();
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      tick();
      redirect_valid = 1'b0;
      chk("end_unfault", 64'(fault), 64'd0);
      chk("end_addr0", 64'(imem_addr), 64'd0);
      exp_push(0);
      tick();
      fetch_en = 1'b0;
      drain();
      // Asynchronous reset with buffered entries
      out_ready = 1'b0; fetch_en = 1'b1;
      tick(); tick();
      chk("ar_full", 64'(out_valid), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("ar_valid", 64'(out_valid), 64'd0);
      chk("ar_addr", 64'(imem_addr), 64'd0);
      tick();
      rst = 1'b0; out_ready = 1'b1;
      exp_push(0);
      tick();
      fetch_en = 1'b0;
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
